// File: rtl/conv_loop_sequencer_pkg.sv
// Shared types and width helpers for the
// convolution loop-nest sequencer.
package conv_seq_pkg;

  localparam int unsigned FM_W_MAX   = 128;
  localparam int unsigned FM_H_MAX   = 128;
  localparam int unsigned IN_CH_MAX  = 2;
  localparam int unsigned OUT_CH_MAX = 16;
  localparam int unsigned KERNEL     = 3;
  localparam int unsigned STRIDE_MAX = 2;

  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cfg_w(
    input int unsigned n
  );
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned crd_w(
    input int unsigned mx,
    input int unsigned s,
    input int unsigned k
  );
    return $clog2(mx * s + k) + 1;
  endfunction

  localparam int unsigned WD_W = cfg_w(FM_W_MAX);
  localparam int unsigned HT_W = cfg_w(FM_H_MAX);
  localparam int unsigned CI_W = cfg_w(IN_CH_MAX);
  localparam int unsigned CO_W = cfg_w(OUT_CH_MAX);
  localparam int unsigned ST_W = cfg_w(STRIDE_MAX);
  localparam int unsigned OX_W = idx_w(FM_W_MAX);
  localparam int unsigned OY_W = idx_w(FM_H_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } seq_state_t;

  // ow_lim/oh_lim hold output extent minus one
  typedef struct packed {
    logic [WD_W-1:0] width;
    logic [HT_W-1:0] height;
    logic [CI_W-1:0] in_ch;
    logic [CO_W-1:0] out_ch;
    logic [ST_W-1:0] stride;
    logic [OX_W-1:0] ow_lim;
    logic [OY_W-1:0] oh_lim;
  } seq_cfg_t;

endpackage

// File: rtl/conv_loop_sequencer_if.sv
// Index tuple bus between the sequencer and
// the MAC datapath, valid/ready handshake.
interface conv_loop_sequencer_if
  import conv_seq_pkg::*;
#(
  parameter int unsigned XW  = idx_w(FM_W_MAX),
  parameter int unsigned YW  = idx_w(FM_H_MAX),
  parameter int unsigned OCW = idx_w(OUT_CH_MAX),
  parameter int unsigned ICW = idx_w(IN_CH_MAX),
  parameter int unsigned KW  = idx_w(KERNEL)
);
  logic           idx_valid;
  logic           idx_ready;
  logic [XW-1:0]  out_x;
  logic [YW-1:0]  out_y;
  logic [OCW-1:0] out_ch;
  logic [XW-1:0]  in_x;
  logic [YW-1:0]  in_y;
  logic [ICW-1:0] in_ch;
  logic [KW-1:0]  kx;
  logic [KW-1:0]  ky;
  logic           zero_flag;
  logic           first_acc;
  logic           last_acc;

  modport master (
    output idx_valid, out_x, out_y, out_ch,
    output in_x, in_y, in_ch, kx, ky,
    output zero_flag, first_acc, last_acc,
    input  idx_ready
  );

  modport slave (
    input  idx_valid, out_x, out_y, out_ch,
    input  in_x, in_y, in_ch, kx, ky,
    input  zero_flag, first_acc, last_acc,
    output idx_ready
  );
endinterface

// File: rtl/conv_loop_sequencer_counter.sv
// Wrapping loop counter; wrap feeds the en of
// the next outer loop level.
module loop_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             arst_in,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == limit);

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      count <= '0;
    end else if (clear || wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Runtime-configurable loop-nest sequencer emitting
// one convolution index tuple per MAC.
module conv_loop_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned FEATURE_MAP_WIDTH  = FM_W_MAX,
  parameter int unsigned FEATURE_MAP_HEIGHT = FM_H_MAX,
  parameter int unsigned INPUT_NB_CHANNELS  = IN_CH_MAX,
  parameter int unsigned OUTPUT_NB_CHANNELS = OUT_CH_MAX,
  parameter int unsigned KERNEL_SIZE        = KERNEL,
  parameter int unsigned MAX_STRIDE         = STRIDE_MAX
) (
  input  logic clk,
  input  logic arst_in,
  input  logic start,
  input  logic abort,
  input  logic [cfg_w(FEATURE_MAP_WIDTH)-1:0]  cfg_width,
  input  logic [cfg_w(FEATURE_MAP_HEIGHT)-1:0] cfg_height,
  input  logic [cfg_w(INPUT_NB_CHANNELS)-1:0]  cfg_in_ch,
  input  logic [cfg_w(OUTPUT_NB_CHANNELS)-1:0] cfg_out_ch,
  input  logic [cfg_w(MAX_STRIDE)-1:0]         cfg_stride,
  output logic running,
  output logic done,
  output logic cfg_error,
  conv_loop_sequencer_if.master idx
);

  localparam int unsigned XW  = idx_w(FEATURE_MAP_WIDTH);
  localparam int unsigned YW  = idx_w(FEATURE_MAP_HEIGHT);
  localparam int unsigned OCW = idx_w(OUTPUT_NB_CHANNELS);
  localparam int unsigned ICW = idx_w(INPUT_NB_CHANNELS);
  localparam int unsigned KW  = idx_w(KERNEL_SIZE);
  localparam int unsigned CWW = cfg_w(FEATURE_MAP_WIDTH);
  localparam int unsigned CHW = cfg_w(FEATURE_MAP_HEIGHT);
  localparam int unsigned CIW = cfg_w(INPUT_NB_CHANNELS);
  localparam int unsigned COW = cfg_w(OUTPUT_NB_CHANNELS);
  localparam int unsigned CSW = cfg_w(MAX_STRIDE);
  localparam int unsigned DMX =
    (FEATURE_MAP_WIDTH > FEATURE_MAP_HEIGHT) ?
    FEATURE_MAP_WIDTH : FEATURE_MAP_HEIGHT;
  localparam int unsigned SW  =
    crd_w(DMX, MAX_STRIDE, KERNEL_SIZE);
  localparam int unsigned PAD = KERNEL_SIZE / 2;
  localparam logic [KW-1:0] K_LIM = KW'(KERNEL_SIZE - 1);

  // release of the async reset is re-timed to clk
  logic [1:0] rst_pipe;
  logic       rst;

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst = rst_pipe[1];

  seq_state_t state;
  seq_state_t nstate;
  seq_cfg_t   cfg_q;
  seq_cfg_t   cfg_d;

  logic legal;
  logic go;
  logic fire;
  logic clear;
  logic last_hs;

  always_comb begin
    cfg_d.width  = cfg_width;
    cfg_d.height = cfg_height;
    cfg_d.in_ch  = cfg_in_ch;
    cfg_d.out_ch = cfg_out_ch;
    cfg_d.stride = cfg_stride;
    cfg_d.ow_lim = XW'((cfg_width - 1'b1) /
                       CWW'(cfg_stride));
    cfg_d.oh_lim = YW'((cfg_height - 1'b1) /
                       CHW'(cfg_stride));
  end

  assign legal =
    (cfg_width  != '0) &&
    (cfg_width  <= CWW'(FEATURE_MAP_WIDTH)) &&
    (cfg_height != '0) &&
    (cfg_height <= CHW'(FEATURE_MAP_HEIGHT)) &&
    (cfg_in_ch  != '0) &&
    (cfg_in_ch  <= CIW'(INPUT_NB_CHANNELS)) &&
    (cfg_out_ch != '0) &&
    (cfg_out_ch <= COW'(OUTPUT_NB_CHANNELS)) &&
    (cfg_stride != '0) &&
    (cfg_stride <= CSW'(MAX_STRIDE));

  assign go    = (state == S_IDLE) && start && legal;
  assign fire  = idx.idx_valid && idx.idx_ready && !abort;
  assign clear = go || abort;

  logic [ICW-1:0] c_ic, n_ic, lim_ic, e_lim_ic;
  logic [KW-1:0]  c_kx, n_kx;
  logic [KW-1:0]  c_ky, n_ky;
  logic [OCW-1:0] c_oc, n_oc, lim_oc;
  logic [XW-1:0]  c_ox, n_ox;
  logic [YW-1:0]  c_oy, n_oy;
  logic w_ic, w_kx, w_ky, w_oc, w_ox, w_oy;

  assign lim_ic = ICW'(cfg_q.in_ch - 1'b1);
  assign lim_oc = OCW'(cfg_q.out_ch - 1'b1);

  loop_counter #(.WIDTH(ICW)) u_ic (
    .clk(clk), .arst_in(rst), .clear(clear),
    .en(fire), .limit(lim_ic),
    .count(c_ic), .wrap(w_ic)
  );

  loop_counter #(.WIDTH(KW)) u_kx (
    .clk(clk), .arst_in(rst), .clear(clear),
    .en(w_ic), .limit(K_LIM),
    .count(c_kx), .wrap(w_kx)
  );

  loop_counter #(.WIDTH(KW)) u_ky (
    .clk(clk), .arst_in(rst), .clear(clear),
    .en(w_kx), .limit(K_LIM),
    .count(c_ky), .wrap(w_ky)
  );

  loop_counter #(.WIDTH(OCW)) u_oc (
    .clk(clk), .arst_in(rst), .clear(clear),
    .en(w_ky), .limit(lim_oc),
    .count(c_oc), .wrap(w_oc)
  );

  loop_counter #(.WIDTH(XW)) u_ox (
    .clk(clk), .arst_in(rst), .clear(clear),
    .en(w_oc), .limit(cfg_q.ow_lim),
    .count(c_ox), .wrap(w_ox)
  );

  loop_counter #(.WIDTH(YW)) u_oy (
    .clk(clk), .arst_in(rst), .clear(clear),
    .en(w_ox), .limit(cfg_q.oh_lim),
    .count(c_oy), .wrap(w_oy)
  );

  assign last_hs = w_oy;

  assign idx.out_x  = c_ox;
  assign idx.out_y  = c_oy;
  assign idx.out_ch = c_oc;
  assign idx.in_ch  = c_ic;
  assign idx.kx     = c_kx;
  assign idx.ky     = c_ky;

  // mirror the counters' next values so the derived
  // fields register in the same cycle as the counts
  always_comb begin
    n_ic = c_ic;
    n_kx = c_kx;
    n_ky = c_ky;
    n_oc = c_oc;
    n_ox = c_ox;
    n_oy = c_oy;
    if (clear) begin
      n_ic = '0;
      n_kx = '0;
      n_ky = '0;
      n_oc = '0;
      n_ox = '0;
      n_oy = '0;
    end else begin
      if (w_ic)      n_ic = '0;
      else if (fire) n_ic = c_ic + 1'b1;
      if (w_kx)      n_kx = '0;
      else if (w_ic) n_kx = c_kx + 1'b1;
      if (w_ky)      n_ky = '0;
      else if (w_kx) n_ky = c_ky + 1'b1;
      if (w_oc)      n_oc = '0;
      else if (w_ky) n_oc = c_oc + 1'b1;
      if (w_ox)      n_ox = '0;
      else if (w_oc) n_ox = c_ox + 1'b1;
      if (w_oy)      n_oy = '0;
      else if (w_ox) n_oy = c_oy + 1'b1;
    end
  end

  // first tuple is computed while cfg is still on the pins
  logic [CWW-1:0] e_width;
  logic [CHW-1:0] e_height;
  logic [CSW-1:0] e_stride;

  assign e_width  = (state == S_IDLE) ?
                    cfg_width : cfg_q.width;
  assign e_height = (state == S_IDLE) ?
                    cfg_height : cfg_q.height;
  assign e_stride = (state == S_IDLE) ?
                    cfg_stride : cfg_q.stride;
  assign e_lim_ic = (state == S_IDLE) ?
                    ICW'(cfg_in_ch - 1'b1) : lim_ic;

  logic [SW-1:0] ix;
  logic [SW-1:0] iy;
  logic          pad;
  logic          first;
  logic          last;

  assign ix = SW'(n_ox) * SW'(e_stride) +
              SW'(n_kx) - SW'(PAD);
  assign iy = SW'(n_oy) * SW'(e_stride) +
              SW'(n_ky) - SW'(PAD);

  // msb is the sign; negatives also fail the upper bound
  assign pad = ix[SW-1] || iy[SW-1] ||
               (ix >= SW'(e_width)) ||
               (iy >= SW'(e_height));

  assign first = (n_ic == '0) && (n_kx == '0) &&
                 (n_ky == '0);
  assign last  = (n_ic == e_lim_ic) &&
                 (n_kx == K_LIM) && (n_ky == K_LIM);

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: if (go) nstate = S_RUN;
      S_RUN: begin
        if (abort)        nstate = S_IDLE;
        else if (last_hs) nstate = S_DONE;
      end
      S_DONE: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      running       <= 1'b0;
      done          <= 1'b0;
      cfg_error     <= 1'b0;
      idx.idx_valid <= 1'b0;
      cfg_q         <= '0;
    end else begin
      state         <= nstate;
      running       <= (nstate == S_RUN);
      idx.idx_valid <= (nstate == S_RUN);
      done          <= (nstate == S_DONE);
      cfg_error     <= (state == S_IDLE) &&
                       start && !legal;
      if (go) cfg_q <= cfg_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx.zero_flag <= 1'b0;
      idx.first_acc <= 1'b0;
      idx.last_acc  <= 1'b0;
      idx.in_x      <= '0;
      idx.in_y      <= '0;
    end else if (nstate == S_RUN) begin
      idx.zero_flag <= pad;
      idx.first_acc <= first;
      idx.last_acc  <= last;
      idx.in_x      <= pad ? '0 : XW'(ix);
      idx.in_y      <= pad ? '0 : YW'(iy);
    end else begin
      idx.zero_flag <= 1'b0;
      idx.first_acc <= 1'b0;
      idx.last_acc  <= 1'b0;
      idx.in_x      <= '0;
      idx.in_y      <= '0;
    end
  end

endmodule
